// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared definitions for the SPI configuration sequencer: table entry layout,
// flag bit positions, error codes and FSM state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Ports: none.
package spi_cfg_sequencer_pkg;

   // Table entry layout, MSB first: {wbits, rbits, flags, expect, data}.
   typedef struct packed {
      logic [7:0]  wbits;
      logic [7:0]  rbits;
      logic [7:0]  flags;
      logic [7:0]  exp_val;
      logic [31:0] data;
   } entry_t;

   localparam int ENTRY_W     = $bits(entry_t);
   localparam int FLAG_VERIFY = 0;
   localparam int FLAG_LAST   = 1;
   localparam int MAX_BITS    = 32;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_VERIFY  = 2'd1,
      ERR_LENGTH  = 2'd2,
      ERR_OVERRUN = 2'd3
   } err_code_e;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_WAIT_TBL  = 4'd2,
      S_ISSUE     = 4'd3,
      S_WAIT_BUSY = 4'd4,
      S_WAIT_DONE = 4'd5,
      S_CHECK     = 4'd6,
      S_GAP       = 4'd7,
      S_DONE      = 4'd8,
      S_ERROR     = 4'd9
   } state_e;

   // Total frame length is formed 9 bits wide so 255+255 cannot wrap into range.
   function automatic logic len_legal(input logic [7:0] wbits, input logic [7:0] rbits);
      logic [8:0] len;
      len = {1'b0, wbits} + {1'b0, rbits};
      return (len != 9'd0) && (len <= 9'(MAX_BITS));
   endfunction

endpackage

// File: rtl/spi_cfg_sequencer_gap_timer.sv
// Down-counter that times the idle gap (CS high) between SPI transactions.
// Latency: expired asserts in the load_val-th enabled cycle after load.
// Backpressure: none; counts every cycle en is high.
// Ports: clk, reset (async active-low), load/load_val (arm), en (count), expired.
module spi_cfg_sequencer_gap_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // The last counted cycle is the one that sees 1, so the gap lasts load_val cycles.
   assign expired = en && (cnt <= CNT_W'(1));

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Walks a table of pre-formatted SPI transactions, issues each, optionally verifies readback.
// Latency: start to first spi_request is 3 clk when spi_busy is low; GAP_CYCLES idle between.
// Backpressure: holds each request in ISSUE until spi_busy is low; abort only acts between transactions.
// Ports: clk/reset; start/abort control; tbl_addr/tbl_rd/tbl_entry table port;
//        spi_* request side; readback/readback_valid; running/done/error/err_addr/err_code status.
module spi_cfg_sequencer
   import spi_cfg_sequencer_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int GAP_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] tbl_addr,
   output logic              tbl_rd,
   input  logic [63:0]       tbl_entry,
   output logic [31:0]       spi_data_out,
   output logic [7:0]        spi_write_bits,
   output logic [7:0]        spi_read_bits,
   output logic              spi_request,
   input  logic              spi_busy,
   input  logic [31:0]       spi_data_in,
   output logic [31:0]       readback,
   output logic              readback_valid,
   output logic              running,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr,
   output logic [1:0]        err_code
);

   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   state_e    state, state_n;
   entry_t    ent;
   logic      cur_verify, cur_last;
   logic [7:0] cur_exp;
   logic      abort_pend, abort_hit;
   logic      run_start, ld_entry, cap_rb, set_err, addr_inc;
   err_code_e err_val;
   logic      gap_load, gap_en, gap_expired;
   logic [5:0] unused_flags;

   assign ent          = entry_t'(tbl_entry);
   assign unused_flags = ent.flags[7:2];

   // A fresh abort pulse counts as much as a latched one wherever abort is acted on.
   assign abort_hit = abort | abort_pend;

   assign running = !(state inside {S_IDLE, S_DONE, S_ERROR});
   assign done    = (state == S_DONE);
   assign error   = (state == S_ERROR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n     = state;
      tbl_rd      = 1'b0;
      spi_request = 1'b0;
      run_start   = 1'b0;
      ld_entry    = 1'b0;
      cap_rb      = 1'b0;
      set_err     = 1'b0;
      err_val     = ERR_NONE;
      addr_inc    = 1'b0;
      gap_load    = 1'b0;
      gap_en      = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start && !abort) begin
               run_start = 1'b1;
               state_n   = S_FETCH;
            end
         end
         S_FETCH: begin
            tbl_rd  = 1'b1;
            state_n = S_WAIT_TBL;
         end
         S_WAIT_TBL: begin
            if (!len_legal(ent.wbits, ent.rbits)) begin
               set_err = 1'b1;
               err_val = ERR_LENGTH;
               state_n = S_ERROR;
            end else begin
               ld_entry = 1'b1;
               state_n  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (abort_hit) begin
               state_n = S_IDLE;
            end else if (!spi_busy) begin
               spi_request = 1'b1;
               state_n     = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            // The SPI interface raises busy the cycle after accepting the request.
            state_n = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!spi_busy) begin
               cap_rb  = 1'b1;
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cur_verify && (readback[7:0] != cur_exp)) begin
               set_err = 1'b1;
               err_val = ERR_VERIFY;
               state_n = S_ERROR;
            end else if (abort_hit) begin
               state_n = S_IDLE;
            end else if (cur_last) begin
               state_n = S_DONE;
            end else if (&tbl_addr) begin
               set_err = 1'b1;
               err_val = ERR_OVERRUN;
               state_n = S_ERROR;
            end else begin
               addr_inc = 1'b1;
               if (GAP_CYCLES == 0) begin
                  state_n = S_FETCH;
               end else begin
                  gap_load = 1'b1;
                  state_n  = S_GAP;
               end
            end
         end
         S_GAP: begin
            gap_en = 1'b1;
            if (abort_hit) begin
               state_n = S_IDLE;
            end else if (gap_expired) begin
               state_n = S_FETCH;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tbl_addr       <= '0;
         abort_pend     <= 1'b0;
         spi_data_out   <= '0;
         spi_write_bits <= '0;
         spi_read_bits  <= '0;
         cur_verify     <= 1'b0;
         cur_last       <= 1'b0;
         cur_exp        <= '0;
         readback       <= '0;
         readback_valid <= 1'b0;
         err_addr       <= '0;
         err_code       <= ERR_NONE;
      end else begin
         readback_valid <= cap_rb;

         if (run_start) begin
            tbl_addr <= '0;
         end else if (addr_inc) begin
            tbl_addr <= tbl_addr + 1'b1;
         end

         // Pending abort only lives while a sequence is in flight.
         if (state_n inside {S_IDLE, S_DONE, S_ERROR}) begin
            abort_pend <= 1'b0;
         end else if (abort && !run_start) begin
            abort_pend <= 1'b1;
         end

         // Request fields stay frozen from ISSUE until the next entry is loaded.
         if (ld_entry) begin
            spi_data_out   <= ent.data;
            spi_write_bits <= ent.wbits;
            spi_read_bits  <= ent.rbits;
            cur_verify     <= ent.flags[FLAG_VERIFY];
            cur_last       <= ent.flags[FLAG_LAST];
            cur_exp        <= ent.exp_val;
         end

         if (cap_rb) begin
            readback <= spi_data_in;
         end

         if (run_start) begin
            err_addr <= '0;
            err_code <= ERR_NONE;
         end else if (set_err) begin
            err_addr <= tbl_addr;
            err_code <= err_val;
         end
      end
   end

   spi_cfg_sequencer_gap_timer #(
      .CNT_W (GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .load_val (GAP_W'(GAP_CYCLES)),
      .en       (gap_en),
      .expired  (gap_expired)
   );

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Bench for spi_cfg_sequencer: behavioural SPI slave + table memory, table-walk reference model.
// Latency: n/a. Backpressure: slave holds busy for a random 1..6 cycles per transaction.
// Ports: none (top-level bench).
module tb_spi_cfg_sequencer;

   localparam int ADDR_W     = 2;
   localparam int GAP_CYCLES = 16;
   localparam int NENT       = 1 << ADDR_W;

   logic              clk, reset, start, abort;
   logic [ADDR_W-1:0] tbl_addr;
   logic              tbl_rd;
   logic [63:0]       tbl_entry;
   logic [31:0]       spi_data_out;
   logic [7:0]        spi_write_bits, spi_read_bits;
   logic              spi_request, spi_busy;
   logic [31:0]       spi_data_in, readback;
   logic              readback_valid, running, done, error;
   logic [ADDR_W-1:0] err_addr;
   logic [1:0]        err_code;

   spi_cfg_sequencer #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .tbl_addr(tbl_addr), .tbl_rd(tbl_rd), .tbl_entry(tbl_entry),
      .spi_data_out(spi_data_out), .spi_write_bits(spi_write_bits),
      .spi_read_bits(spi_read_bits), .spi_request(spi_request),
      .spi_busy(spi_busy), .spi_data_in(spi_data_in),
      .readback(readback), .readback_valid(readback_valid),
      .running(running), .done(done), .error(error),
      .err_addr(err_addr), .err_code(err_code)
   );

   logic [63:0] tbl [NENT];
   logic [31:0] rsp [NENT];
   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int c0      = 0;
   logic [31:0] model_rb = '0;

   logic [31:0] log_data[$];
   logic [7:0]  log_w[$], log_r[$];
   int          log_cyc[$], log_idle[$];
   int rb_pulses = 0, stable_err = 0;
   bit pend = 0, drop = 0, hold = 0;
   int cnt = 0, idle = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Table memory and SPI slave, both updated mid-cycle on the falling edge.
   initial begin
      spi_busy = 1'b0; spi_data_in = '0; tbl_entry = '0;
      forever begin
         @(negedge clk);
         if (tbl_rd) begin
            tbl_entry = tbl[tbl_addr];
            hold = 1;
         end else if (hold) begin
            hold = 0;
         end else begin
            tbl_entry = {$urandom, $urandom};
         end
         if (readback_valid) rb_pulses++;
         if (!reset) begin
            spi_busy = 1'b0; pend = 0; drop = 0; cnt = 0; idle = 0;
            spi_data_in = $urandom;
         end else begin
            if ((pend || spi_busy) && log_data.size() > 0) begin
               if (spi_data_out !== log_data[log_data.size()-1] ||
                   spi_write_bits !== log_w[log_w.size()-1] ||
                   spi_read_bits !== log_r[log_r.size()-1])
                  stable_err++;
            end
            if (drop) begin
               spi_data_in = $urandom;
               drop = 0;
            end
            if (pend) begin
               spi_busy = 1'b1;
               cnt = $urandom_range(1, 6);
               pend = 0;
            end else if (spi_busy) begin
               cnt--;
               if (cnt == 0) begin
                  spi_busy = 1'b0;
                  spi_data_in = rsp[(log_data.size() - 1) % NENT];
                  drop = 1;
                  idle = 0;
               end
            end else begin
               idle++;
               if (spi_request) begin
                  log_data.push_back(spi_data_out);
                  log_w.push_back(spi_write_bits);
                  log_r.push_back(spi_read_bits);
                  log_cyc.push_back(cyc);
                  log_idle.push_back(idle);
                  pend = 1;
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] mk(input int w, input int r, input int fl, input int ex,
                                      input logic [31:0] d);
      return {8'(w), 8'(r), 8'(fl), 8'(ex), d};
   endfunction

   task automatic run_seq(output bit timed_out);
      log_data.delete(); log_w.delete(); log_r.delete(); log_cyc.delete(); log_idle.delete();
      rb_pulses = 0; stable_err = 0;
      start = 1'b1; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      timed_out = 1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!running) begin
            timed_out = 0;
            break;
         end
      end
   endtask

   // Reference: walk the table by the sequencer's rules and compare the whole outcome.
   task automatic check_run(input string tag, input bit timed_out);
      int e_req, e_code, e_addr, n;
      bit e_done, e_err;
      e_req = 0; e_code = 0; e_addr = 0; e_done = 0; e_err = 0;
      for (int a = 0; a < NENT; a++) begin
         int w, r;
         logic [7:0] fl, ex;
         w  = int'(tbl[a][63:56]);
         r  = int'(tbl[a][55:48]);
         fl = tbl[a][47:40];
         ex = tbl[a][39:32];
         if (w + r == 0 || w + r > 32) begin
            e_err = 1; e_code = 2; e_addr = a; break;
         end
         e_req++;
         model_rb = rsp[a];
         if (fl[0] && rsp[a][7:0] != ex) begin
            e_err = 1; e_code = 1; e_addr = a; break;
         end
         if (fl[1]) begin
            e_done = 1; break;
         end
         if (a == NENT - 1) begin
            e_err = 1; e_code = 3; e_addr = a;
         end
      end
      chk({tag, "/timeout"}, 64'(timed_out), 64'(0));
      chk({tag, "/nreq"}, 64'(log_data.size()), 64'(e_req));
      n = (log_data.size() < e_req) ? log_data.size() : e_req;
      for (int k = 0; k < n; k++) begin
         chk({tag, "/req_data"}, 64'(log_data[k]), 64'(tbl[k][31:0]));
         chk({tag, "/req_wbits"}, 64'(log_w[k]), 64'(tbl[k][63:56]));
         chk({tag, "/req_rbits"}, 64'(log_r[k]), 64'(tbl[k][55:48]));
      end
      if (n > 0) chk({tag, "/start_latency"}, 64'(log_cyc[0] - c0), 64'(3));
      // Between requests busy stays low for CHECK, the gap, FETCH, WAIT_TBL and the ISSUE cycle.
      for (int k = 1; k < n; k++)
         chk({tag, "/gap"}, 64'(log_idle[k]), 64'(GAP_CYCLES + 4));
      chk({tag, "/done"}, 64'(done), 64'(e_done));
      chk({tag, "/error"}, 64'(error), 64'(e_err));
      if (e_err) begin
         chk({tag, "/err_code"}, 64'(err_code), 64'(e_code));
         chk({tag, "/err_addr"}, 64'(err_addr), 64'(e_addr));
      end
      chk({tag, "/readback"}, 64'(readback), 64'(model_rb));
      chk({tag, "/rb_pulses"}, 64'(rb_pulses), 64'(e_req));
      chk({tag, "/stable"}, 64'(stable_err), 64'(0));
   endtask

   task automatic wait_busy(input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (spi_busy) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "/busy_seen"}, 64'(seen), 64'(1));
   endtask

   initial begin
      bit to;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      for (int a = 0; a < NENT; a++) begin
         tbl[a] = '0;
         rsp[a] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset/spi_side", {tbl_addr, tbl_rd, spi_data_out, spi_write_bits, spi_read_bits, spi_request},
          64'(0));
      chk("reset/status", {readback, readback_valid, running, done, error, err_addr, err_code}, 64'(0));
      reset = 1'b1;
      @(negedge clk);

      // Two entries, verify passes on the last one.
      tbl[0] = mk(16, 0, 0, 0, 32'h00A5_1234);
      tbl[1] = mk(8, 8, 3, 8'h5A, 32'hC3C3_0000);
      rsp[0] = 32'h1111_2222; rsp[1] = 32'hDEAD_BE5A;
      run_seq(to); check_run("two_ok", to);

      // Same table, readback mismatch on entry 1.
      rsp[1] = 32'h0000_003C;
      run_seq(to); check_run("verify_fail", to);

      // Illegal length on the first entry: no request at all.
      tbl[0] = mk(24, 16, 2, 0, 32'h1);
      run_seq(to); check_run("bad_len", to);

      // No LAST anywhere: table overrun after the final address.
      for (int a = 0; a < NENT; a++) begin
         tbl[a] = mk(8 + a, 4, 0, 0, $urandom);
         rsp[a] = $urandom;
      end
      run_seq(to); check_run("overrun", to);

      // start together with abort while idle: abort wins, nothing starts.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort/running", 64'(running), 64'(0));

      // Abort in the middle of entry 0: that transaction still finishes.
      log_data.delete(); log_w.delete(); log_r.delete(); log_cyc.delete(); log_idle.delete();
      rb_pulses = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_busy("abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      to = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!running) begin
            to = 0;
            break;
         end
      end
      repeat (GAP_CYCLES + 8) @(negedge clk);
      model_rb = rsp[0];
      chk("abort/timeout", 64'(to), 64'(0));
      chk("abort/nreq", 64'(log_data.size()), 64'(1));
      chk("abort/running", 64'(running), 64'(0));
      chk("abort/done", 64'(done), 64'(0));
      chk("abort/error", 64'(error), 64'(0));
      chk("abort/readback", 64'(readback), 64'(model_rb));
      chk("abort/rb_pulses", 64'(rb_pulses), 64'(1));

      // Reset while a transaction is in flight: outputs clear without a clock edge.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_busy("mid_reset");
      #2 reset = 1'b0;
      #1;
      chk("mid_reset/spi_side", {tbl_addr, tbl_rd, spi_data_out, spi_write_bits, spi_read_bits, spi_request},
          64'(0));
      chk("mid_reset/status", {readback, readback_valid, running, done, error, err_addr, err_code},
          64'(0));
      model_rb = '0;
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);

      // Random tables against the reference walk.
      for (int it = 0; it < 12; it++) begin
         for (int a = 0; a < NENT; a++) begin
            int w, r, fl;
            logic [7:0] ex;
            w  = $urandom_range(0, 24);
            r  = $urandom_range(0, 16);
            fl = ($urandom_range(0, 3) == 0) ? 2 : 0;
            fl = fl | int'($urandom_range(0, 1));
            rsp[a] = $urandom;
            ex = ($urandom_range(0, 3) != 0) ? rsp[a][7:0] : 8'($urandom);
            tbl[a] = mk(w, r, fl, int'(ex), $urandom);
         end
         run_seq(to);
         check_run($sformatf("rand%0d", it), to);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
